jtcop_dwnld: RTL and testbench

//  Converts the ioctl byte stream received during ROM/NVRAM download into SDRAM

---
 rtl/jtcop_dwnld.sv | 239 +++++++++++++++++++++++
 tb/tb_jtcop_dwnld.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcop_dwnld.sv
// ---------------------------------------------------------------------------
// jtcop_dwnld
//
// Turns the ioctl download byte stream (ROM or NVRAM) into SDRAM programming
// writes for the four banks used by jtcop_sdram. Each byte is routed to a
// bank according to its address region. A two-entry FIFO absorbs bytes while
// an SDRAM write is still in flight. With JTCOP_MCU_EN defined, the i8751 MCU
// firmware region is diverted to the MCU program RAM via mcu_we. Without it,
// MCU bytes are dropped and mcu_we is tied low.
//
// Configuration macro: JTCOP_MCU_EN
//
// Ports
//   clk, rst      system clock, synchronous active-high reset
//   downloading   download in progress
//   ioctl_addr    byte address of the incoming byte
//   ioctl_dout    incoming byte
//   ioctl_wr      one-cycle strobe marking a valid byte
//   ioctl_ram     0 = ROM stream, 1 = NVRAM stream
//   prog_addr     SDRAM word address (its low 12 bits are also the MCU RAM address)
//   prog_data     write data, byte duplicated in both lanes
//   prog_mask     per-byte mask, 1 = lane not written
//   prog_ba       target SDRAM bank
//   prog_we       write request, held until prog_ack
//   prog_rd       always 0
//   prog_ack      SDRAM accepted the request
//   prog_rdy      SDRAM finished the write
//   mcu_we        one-cycle MCU program RAM write strobe
//   dwnld_busy    download active or a write still pending
//   ovf           sticky flag: a byte was lost because the FIFO was full
// ---------------------------------------------------------------------------
module jtcop_dwnld #(
    parameter logic [24:0] BA1_START  = 25'h08_0000,
    parameter logic [24:0] BA2_START  = 25'h10_0000,
    parameter logic [24:0] BA3_START  = 25'h20_0000,
    parameter logic [24:0] MCU_START  = 25'h30_0000,
    parameter logic [24:0] PROM_END   = 25'h30_1000,
    parameter logic [21:0] RAM_OFFSET = 22'h3F_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    input  logic        ioctl_ram,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    output logic        prog_rd,
    input  logic        prog_ack,
    input  logic        prog_rdy,
    output logic        mcu_we,
    output logic        dwnld_busy,
    output logic        ovf
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
        logic        is_mcu;
    } entry_t;

    state_t     state, state_nx;
    entry_t     new_entry;
    entry_t     fifo0, fifo1;
    logic [1:0] count;
    logic       keep;
    logic       full;
    logic       push;
    logic       pop;
    logic       load;
    logic       lost;
`ifdef JTCOP_MCU_EN
    logic       mcu_fire;
`endif

    assign prog_rd    = 1'b0;
    assign dwnld_busy = downloading | (count != 2'd0) | (state != ST_IDLE);

    // Region decode of the incoming byte. The highest region start that is
    // not above the address wins. Bytes past the valid data are not kept.
    always_comb begin
        new_entry      = '0;
        keep           = 1'b0;
        new_entry.data = ioctl_dout;
        new_entry.mask = ioctl_addr[0] ? 2'b10 : 2'b01;
        if (ioctl_ram) begin
            keep           = 1'b1;
            new_entry.ba   = 2'd0;
            new_entry.addr = RAM_OFFSET + {1'b0, ioctl_addr[21:1]};
        end else if (ioctl_addr >= PROM_END) begin
            keep = 1'b0;
        end else if (ioctl_addr >= MCU_START) begin
`ifdef JTCOP_MCU_EN
            keep             = 1'b1;
            new_entry.is_mcu = 1'b1;
            new_entry.addr   = 22'((ioctl_addr - MCU_START) >> 1);
`else
            keep = 1'b0;
`endif
        end else if (ioctl_addr >= BA3_START) begin
            keep           = 1'b1;
            new_entry.ba   = 2'd3;
            new_entry.addr = 22'((ioctl_addr - BA3_START) >> 1);
        end else if (ioctl_addr >= BA2_START) begin
            keep           = 1'b1;
            new_entry.ba   = 2'd2;
            new_entry.addr = 22'((ioctl_addr - BA2_START) >> 1);
        end else if (ioctl_addr >= BA1_START) begin
            keep           = 1'b1;
            new_entry.ba   = 2'd1;
            new_entry.addr = 22'((ioctl_addr - BA1_START) >> 1);
        end else begin
            keep           = 1'b1;
            new_entry.ba   = 2'd0;
            new_entry.addr = 22'(ioctl_addr >> 1);
        end
    end

    // A push into a full FIFO only succeeds if the head leaves the same cycle.
    assign full = (count == 2'd2);
    assign push = ioctl_wr & keep & (~full | pop);
    assign lost = ioctl_wr & keep & full & ~pop;

    // Next-state logic. An SDRAM entry stays at the FIFO head until it is
    // acknowledged. MCU entries leave the FIFO the cycle they reach IDLE.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        load     = 1'b0;
        prog_we  = 1'b0;
`ifdef JTCOP_MCU_EN
        mcu_fire = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (count != 2'd0) begin
                    load = 1'b1;
                    if (fifo0.is_mcu) begin
                        pop = 1'b1;
`ifdef JTCOP_MCU_EN
                        mcu_fire = 1'b1;
`endif
                    end else begin
                        state_nx = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                prog_we = 1'b1;
                if (prog_ack) begin
                    pop      = 1'b1;
                    state_nx = prog_rdy ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (prog_rdy) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FIFO storage. fifo0 is always the head. On a pop, the second entry moves
    // forward. A simultaneous push lands behind whatever remains.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo0 <= '0;
            fifo1 <= '0;
            count <= 2'd0;
            ovf   <= 1'b0;
        end else begin
            if (pop) begin
                fifo0 <= fifo1;
            end
            if (push) begin
                if ((count - {1'b0, pop}) == 2'd0) begin
                    fifo0 <= new_entry;
                end else begin
                    fifo1 <= new_entry;
                end
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (lost) begin
                ovf <= 1'b1;
            end
        end
    end

    // Write outputs are captured from the head as it is launched and then held.
    always_ff @(posedge clk) begin
        if (rst) begin
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= '0;
            prog_ba   <= '0;
        end else if (load) begin
            prog_addr <= fifo0.addr;
            prog_data <= {fifo0.data, fifo0.data};
            prog_mask <= fifo0.mask;
            prog_ba   <= fifo0.ba;
        end
    end

`ifdef JTCOP_MCU_EN
    // The MCU RAM strobe lines up with the prog_addr/prog_data update.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcu_we <= 1'b0;
        end else begin
            mcu_we <= mcu_fire;
        end
    end
`else
    assign mcu_we = 1'b0;
`endif

endmodule

// File: tb/tb_jtcop_dwnld.sv
module tb_jtcop_dwnld;

    logic        clk;
    logic        rst;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        ioctl_ram;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        prog_rd;
    logic        prog_ack;
    logic        prog_rdy;
    logic        mcu_we;
    logic        dwnld_busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    jtcop_dwnld dut (
        .clk        (clk),
        .rst        (rst),
        .downloading(downloading),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .ioctl_wr   (ioctl_wr),
        .ioctl_ram  (ioctl_ram),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .prog_ba    (prog_ba),
        .prog_we    (prog_we),
        .prog_rd    (prog_rd),
        .prog_ack   (prog_ack),
        .prog_rdy   (prog_rdy),
        .mcu_we     (mcu_we),
        .dwnld_busy (dwnld_busy),
        .ovf        (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input logic r);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_ram  = r;
        ioctl_wr   = 1'b1;
        step();
        ioctl_wr   = 1'b0;
    endtask

    task automatic ack_and_rdy();
        prog_ack = 1'b1;
        prog_rdy = 1'b1;
        step();
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (prog_we !== 1'b0 || mcu_we !== 1'b0 || ovf !== 1'b0 || prog_rd !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: we=%b mcu_we=%b ovf=%b rd=%b expected 0 0 0 0",
                     prog_we, mcu_we, ovf, prog_rd);
        end
        checks++;
        if (prog_addr !== 22'd0 || prog_data !== 16'd0 || prog_mask !== 2'd0 || prog_ba !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: addr=%h data=%h mask=%b ba=%0d expected all 0",
                     prog_addr, prog_data, prog_mask, prog_ba);
        end
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy: busy=%b expected 0", dwnld_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_rom();
        downloading = 1'b1;
        send_byte(25'h000001, 8'hA5, 1'b0);
        checks++;
        if (prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_latency1: we=%b expected 0", prog_we);
        end
        step();
        checks++;
        if (prog_we !== 1'b1 || prog_ba !== 2'd0 || prog_addr !== 22'd0 ||
            prog_data !== 16'hA5A5 || prog_mask !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_req: we=%b ba=%0d addr=%h data=%h mask=%b expected 1 0 000000 a5a5 10",
                     prog_we, prog_ba, prog_addr, prog_data, prog_mask);
        end
        step();
        step();
        checks++;
        if (prog_we !== 1'b1 || prog_data !== 16'hA5A5) begin
            errors++;
            $display("[TB] FAIL single_hold: we=%b data=%h expected 1 a5a5", prog_we, prog_data);
        end
        prog_ack = 1'b1;
        step();
        prog_ack = 1'b0;
        downloading = 1'b0;
        checks++;
        if (prog_we !== 1'b0 || dwnld_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_wait: we=%b busy=%b expected 0 1", prog_we, dwnld_busy);
        end
        step();
        checks++;
        if (dwnld_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_wait_busy: busy=%b expected 1", dwnld_busy);
        end
        prog_rdy = 1'b1;
        step();
        prog_rdy = 1'b0;
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_busy_fall: busy=%b expected 0", dwnld_busy);
        end
    endtask

    task automatic test_regions();
        logic [24:0] va [7];
        logic [7:0]  vd [7];
        logic [1:0]  vba[7];
        logic [21:0] vwa[7];
        logic [1:0]  vm [7];
        va[0] = 25'h100004; vd[0] = 8'h3C; vba[0] = 2'd2; vwa[0] = 22'h000002; vm[0] = 2'b01;
        va[1] = 25'h200000; vd[1] = 8'h5A; vba[1] = 2'd3; vwa[1] = 22'h000000; vm[1] = 2'b01;
        va[2] = 25'h080002; vd[2] = 8'h81; vba[2] = 2'd1; vwa[2] = 22'h000001; vm[2] = 2'b01;
        va[3] = 25'h0FFFFF; vd[3] = 8'hC3; vba[3] = 2'd1; vwa[3] = 22'h03FFFF; vm[3] = 2'b10;
        va[4] = 25'h1FFFFE; vd[4] = 8'h0F; vba[4] = 2'd2; vwa[4] = 22'h07FFFF; vm[4] = 2'b01;
        va[5] = 25'h2FFFFF; vd[5] = 8'hF0; vba[5] = 2'd3; vwa[5] = 22'h07FFFF; vm[5] = 2'b10;
        va[6] = 25'h07FFFF; vd[6] = 8'h12; vba[6] = 2'd0; vwa[6] = 22'h03FFFF; vm[6] = 2'b10;
        downloading = 1'b1;
        for (int i = 0; i < 7; i++) begin
            send_byte(va[i], vd[i], 1'b0);
            step();
            checks++;
            if (prog_we !== 1'b1 || prog_ba !== vba[i] || prog_addr !== vwa[i] ||
                prog_mask !== vm[i] || prog_data !== {vd[i], vd[i]}) begin
                errors++;
                $display("[TB] FAIL region_%0d: we=%b ba=%0d addr=%h mask=%b data=%h expected 1 %0d %h %b %h",
                         i, prog_we, prog_ba, prog_addr, prog_mask, prog_data,
                         vba[i], vwa[i], vm[i], {vd[i], vd[i]});
            end
            ack_and_rdy();
            checks++;
            if (prog_we !== 1'b0) begin
                errors++;
                $display("[TB] FAIL region_done_%0d: we=%b expected 0", i, prog_we);
            end
        end
    endtask

    task automatic test_nvram();
        downloading = 1'b1;
        send_byte(25'h000010, 8'h77, 1'b1);
        ioctl_ram = 1'b0;
        step();
        checks++;
        if (prog_we !== 1'b1 || prog_ba !== 2'd0 || prog_addr !== 22'h3F8008 ||
            prog_mask !== 2'b01 || prog_data !== 16'h7777) begin
            errors++;
            $display("[TB] FAIL nvram: we=%b ba=%0d addr=%h mask=%b data=%h expected 1 0 3f8008 01 7777",
                     prog_we, prog_ba, prog_addr, prog_mask, prog_data);
        end
        ack_and_rdy();
    endtask

    task automatic test_overflow();
        downloading = 1'b1;
        ioctl_ram   = 1'b0;
        ioctl_wr    = 1'b1;
        ioctl_addr  = 25'h000000; ioctl_dout = 8'h11; step();
        ioctl_addr  = 25'h000002; ioctl_dout = 8'h22; step();
        ioctl_addr  = 25'h000004; ioctl_dout = 8'h33; step();
        ioctl_wr    = 1'b0;
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: ovf=%b expected 1", ovf);
        end
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 22'd0 || prog_data !== 16'h1111) begin
            errors++;
            $display("[TB] FAIL ovf_first: we=%b addr=%h data=%h expected 1 000000 1111",
                     prog_we, prog_addr, prog_data);
        end
        ack_and_rdy();
        step();
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 22'd1 || prog_data !== 16'h2222) begin
            errors++;
            $display("[TB] FAIL ovf_second: we=%b addr=%h data=%h expected 1 000001 2222",
                     prog_we, prog_addr, prog_data);
        end
        ack_and_rdy();
        step();
        step();
        checks++;
        if (prog_we !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_third_lost: we=%b ovf=%b expected 0 1", prog_we, ovf);
        end

        // Clear the sticky flag, then push into a full FIFO while it pops.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h000010; ioctl_dout = 8'h44; step();
        ioctl_addr = 25'h000012; ioctl_dout = 8'h55; step();
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 22'h000008 || prog_data !== 16'h4444) begin
            errors++;
            $display("[TB] FAIL pushpop_first: we=%b addr=%h data=%h expected 1 000008 4444",
                     prog_we, prog_addr, prog_data);
        end
        ioctl_addr = 25'h000014; ioctl_dout = 8'h66;
        prog_ack = 1'b1;
        prog_rdy = 1'b1;
        step();
        ioctl_wr = 1'b0;
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
        step();
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 22'h000009 || prog_data !== 16'h5555) begin
            errors++;
            $display("[TB] FAIL pushpop_second: we=%b addr=%h data=%h expected 1 000009 5555",
                     prog_we, prog_addr, prog_data);
        end
        ack_and_rdy();
        step();
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 22'h00000A || prog_data !== 16'h6666) begin
            errors++;
            $display("[TB] FAIL pushpop_third: we=%b addr=%h data=%h expected 1 00000a 6666",
                     prog_we, prog_addr, prog_data);
        end
        ack_and_rdy();
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pushpop_ovf: ovf=%b expected 0", ovf);
        end
    endtask

    task automatic test_mcu();
        downloading = 1'b1;
        send_byte(25'h300123, 8'h55, 1'b0);
        step();
`ifdef JTCOP_MCU_EN
        checks++;
        if (mcu_we !== 1'b1 || prog_addr[11:0] !== 12'h091 || prog_data !== 16'h5555 || prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mcu_write: mcu_we=%b addr=%h data=%h we=%b expected 1 091 5555 0",
                     mcu_we, prog_addr[11:0], prog_data, prog_we);
        end
        step();
        checks++;
        if (mcu_we !== 1'b0 || prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mcu_pulse: mcu_we=%b we=%b expected 0 0", mcu_we, prog_we);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h300000; ioctl_dout = 8'hA1; step();
        ioctl_addr = 25'h300002; ioctl_dout = 8'hB2; step();
        ioctl_wr   = 1'b0;
        checks++;
        if (mcu_we !== 1'b1 || prog_addr[11:0] !== 12'h000 || prog_data !== 16'hA1A1) begin
            errors++;
            $display("[TB] FAIL mcu_b2b_first: mcu_we=%b addr=%h data=%h expected 1 000 a1a1",
                     mcu_we, prog_addr[11:0], prog_data);
        end
        step();
        checks++;
        if (mcu_we !== 1'b1 || prog_addr[11:0] !== 12'h001 || prog_data !== 16'hB2B2) begin
            errors++;
            $display("[TB] FAIL mcu_b2b_second: mcu_we=%b addr=%h data=%h expected 1 001 b2b2",
                     mcu_we, prog_addr[11:0], prog_data);
        end
        step();
        checks++;
        if (mcu_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mcu_b2b_end: mcu_we=%b expected 0", mcu_we);
        end
`else
        checks++;
        if (mcu_we !== 1'b0 || prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mcu_off: mcu_we=%b we=%b expected 0 0", mcu_we, prog_we);
        end
        step();
        downloading = 1'b0;
        #1;
        checks++;
        if (mcu_we !== 1'b0 || prog_we !== 1'b0 || dwnld_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mcu_off_drop: mcu_we=%b we=%b busy=%b expected 0 0 0",
                     mcu_we, prog_we, dwnld_busy);
        end
        downloading = 1'b1;
`endif
    endtask

    task automatic test_reset_midwrite();
        downloading = 1'b1;
        ioctl_ram   = 1'b0;
        ioctl_wr    = 1'b1;
        ioctl_addr  = 25'h000020; ioctl_dout = 8'h01; step();
        ioctl_addr  = 25'h000022; ioctl_dout = 8'h02; step();
        ioctl_addr  = 25'h000024; ioctl_dout = 8'h03; step();
        ioctl_wr    = 1'b0;
        checks++;
        if (prog_we !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midwrite_setup: we=%b ovf=%b expected 1 1", prog_we, ovf);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        downloading = 1'b0;
        #1;
        checks++;
        if (prog_we !== 1'b0 || ovf !== 1'b0 || dwnld_busy !== 1'b0 || prog_addr !== 22'd0) begin
            errors++;
            $display("[TB] FAIL midwrite_reset: we=%b ovf=%b busy=%b addr=%h expected 0 0 0 000000",
                     prog_we, ovf, dwnld_busy, prog_addr);
        end
        step();
        step();
        checks++;
        if (prog_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midwrite_no_ack: we=%b expected 0", prog_we);
        end
        downloading = 1'b1;
        send_byte(25'h301000, 8'hEE, 1'b0);
        downloading = 1'b0;
        #1;
        checks++;
        if (dwnld_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_busy: busy=%b expected 0", dwnld_busy);
        end
        step();
        checks++;
        if (prog_we !== 1'b0 || mcu_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drop_end: we=%b mcu_we=%b expected 0 0", prog_we, mcu_we);
        end
    endtask

    initial begin
        rst         = 1'b1;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        ioctl_wr    = 1'b0;
        ioctl_ram   = 1'b0;
        prog_ack    = 1'b0;
        prog_rdy    = 1'b0;
        #2;
        test_reset();
        test_single_rom();
        test_regions();
        test_nvram();
        test_overflow();
        test_mcu();
        test_reset_midwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
